// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and block-geometry constants for the cache fill arbiter.
package cache_fill_pkg;

    localparam int BLK_WORDS    = 8;
    localparam int CNT_W        = 3;
    localparam int PKG_ADDR_W   = 16;
    localparam logic [PKG_ADDR_W-1:0] BLK_OFF_MASK = PKG_ADDR_W'(2 * BLK_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_FILL_I,
        ST_FILL_D,
        ST_DONE
    } state_e;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_e;

endpackage

// File: rtl/cache_fill_arbiter_word_counter.sv
// Word index counter within one cache block; clear wins over increment.
module block_word_counter
    import cache_fill_pkg::*;
#(
    parameter int WORDS = BLK_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(WORDS - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares the pipelined main memory between I-fill, D-fill and D write-through;
// issues block reads and steers returning words into the winning cache.
module cache_fill_arbiter
    import cache_fill_pkg::*;
#(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [15:0]       d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_data_valid,
    output logic              fill_we_i,
    output logic              fill_we_d,
    output logic [2:0]        fill_word,
    output logic [15:0]       fill_data,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_done,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

    // The counters are fixed at CNT_W bits, so the block must match them.
    if (MEM_LATENCY < 1 || WORDS_PER_BLOCK != (1 << CNT_W)) begin : g_bad_cfg
        $error("cache_fill_arbiter: unsupported MEM_LATENCY/WORDS_PER_BLOCK");
    end

    state_e            state_q, state_d;
    req_id_e           req_q, req_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              issue_done_q, issue_done_d;

    logic             in_fill;
    logic             issue_inc, issue_last;
    logic             recv_inc, recv_last;
    logic [CNT_W-1:0] issue_cnt, recv_cnt;
    logic             idle;

    assign idle      = (state_q == ST_IDLE);
    assign in_fill   = (state_q == ST_FILL_I) || (state_q == ST_FILL_D);
    assign issue_inc = in_fill && !issue_done_q;
    assign recv_inc  = in_fill && mem_data_valid;

    block_word_counter #(.WORDS(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (idle),
        .inc  (issue_inc),
        .cnt  (issue_cnt),
        .last (issue_last)
    );

    block_word_counter #(.WORDS(WORDS_PER_BLOCK)) u_recv_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (idle),
        .inc  (recv_inc),
        .cnt  (recv_cnt),
        .last (recv_last)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        base_d       = base_q;
        issue_done_d = issue_done_q | (issue_inc & issue_last);
        case (state_q)
            ST_IDLE: begin
                issue_done_d = 1'b0;
                // D side is older in program order, so it wins.
                if (d_wr_req) begin
                    state_d = ST_WRITE;
                end else if (d_miss) begin
                    state_d = ST_FILL_D;
                    req_d   = REQ_D;
                    base_d  = d_addr & ~OFF_MASK;
                end else if (i_miss) begin
                    state_d = ST_FILL_I;
                    req_d   = REQ_I;
                    base_d  = i_addr & ~OFF_MASK;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_FILL_I,
            ST_FILL_D: begin
                if (mem_data_valid && recv_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= REQ_I;
            base_q       <= '0;
            issue_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            base_q       <= base_d;
            issue_done_q <= issue_done_d;
        end
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        d_wr_done   = 1'b0;
        fill_we_i   = 1'b0;
        fill_we_d   = 1'b0;
        fill_word   = '0;
        fill_data   = '0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        busy        = !idle;
        if (state_q == ST_WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_wr_addr;
            mem_wdata = d_wr_data;
            d_wr_done = 1'b1;
        end
        if (issue_inc) begin
            // OR-ing the offset into the aligned base can never carry out of the block.
            mem_en   = 1'b1;
            mem_addr = base_q | ADDR_W'({issue_cnt, 1'b0});
        end
        if (recv_inc) begin
            fill_we_i = (state_q == ST_FILL_I);
            fill_we_d = (state_q == ST_FILL_D);
            fill_word = recv_cnt;
            fill_data = mem_rdata;
        end
        if (state_q == ST_DONE) begin
            i_fill_done = (req_q == REQ_I);
            d_fill_done = (req_q == REQ_D);
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: directed requests push expected
// memory/fill/done events; a negedge monitor pops and compares them.
module tb_cache_fill_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_data_valid;
    logic        fill_we_i, fill_we_d;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_fill_done, d_fill_done, d_wr_done, busy;

    cache_fill_arbiter #(.MEM_LATENCY(LAT), .WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .fill_we_i(fill_we_i), .fill_we_d(fill_we_d), .fill_word(fill_word), .fill_data(fill_data),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_done(d_wr_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], ~a[15:8]} ^ 16'h3C5A;
    endfunction

    // Memory model: reads sampled in cycle k return in cycle k+LAT.
    logic [LAT-1:0] pv = '0;
    logic [15:0]    pa [LAT];
    logic           stray_v = 1'b0;
    logic           rv;
    logic [15:0]    ra;

    always begin
        @(negedge clk);
        rv = mem_en && !mem_wr;
        ra = mem_addr;
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = rv;
        pa[0] = ra;
    end

    assign mem_data_valid = pv[LAT-1] | stray_v;
    assign mem_rdata      = pv[LAT-1] ? memf(pa[LAT-1]) : (stray_v ? 16'h5555 : 16'hDEAD);

    typedef struct { int cyc; logic [15:0] a; logic [15:0] d; logic wr; } mem_exp_t;
    typedef struct { int cyc; logic [1:0] sd; logic [2:0] w; logic [15:0] d; } fill_exp_t;
    typedef struct { int cyc; logic [1:0] sd; } done_exp_t;

    mem_exp_t  mem_q [$];
    fill_exp_t fill_q [$];
    done_exp_t done_q [$];

    // sd encodes {we_i, we_d} / {i_done, d_done}.
    task automatic push_fill(input logic is_d, input logic [15:0] base, input int t);
        logic [1:0] sd;
        logic [15:0] a;
        sd = is_d ? 2'b01 : 2'b10;
        for (int k = 0; k < 8; k++) begin
            a = base + 16'(2 * k);
            mem_q.push_back('{t + k, a, 16'h0, 1'b0});
            fill_q.push_back('{t + LAT + k, sd, 3'(k), memf(a)});
        end
        done_q.push_back('{t + 12, sd});
    endtask

    mem_exp_t  me;
    fill_exp_t fe;
    done_exp_t de;

    always @(negedge clk) begin
        if (mem_en || d_wr_done) begin
            if (mem_q.size() == 0) begin
                total++; bad++;
                $display("FAIL mem_unexpected: got addr %0h wr %0b at cycle %0d want none", mem_addr, mem_wr, cyc);
            end else begin
                me = mem_q.pop_front();
                chk("mem_cycle", 64'(cyc), 64'(me.cyc));
                chk("mem_en", 64'(mem_en), 64'd1);
                chk("mem_wr", 64'(mem_wr), 64'(me.wr));
                chk("mem_addr", 64'(mem_addr), 64'(me.a));
                chk("d_wr_done", 64'(d_wr_done), 64'(me.wr));
                if (me.wr) chk("mem_wdata", 64'(mem_wdata), 64'(me.d));
            end
        end
        if (fill_we_i || fill_we_d) begin
            if (fill_q.size() == 0) begin
                total++; bad++;
                $display("FAIL fill_unexpected: got we %0b%0b word %0d at cycle %0d want none", fill_we_i, fill_we_d, fill_word, cyc);
            end else begin
                fe = fill_q.pop_front();
                chk("fill_cycle", 64'(cyc), 64'(fe.cyc));
                chk("fill_side", 64'({fill_we_i, fill_we_d}), 64'(fe.sd));
                chk("fill_word", 64'(fill_word), 64'(fe.w));
                chk("fill_data", 64'(fill_data), 64'(fe.d));
            end
        end
        if (i_fill_done || d_fill_done) begin
            if (done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL done_unexpected: got %0b%0b at cycle %0d want none", i_fill_done, d_fill_done, cyc);
            end else begin
                de = done_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(de.cyc));
                chk("done_side", 64'({i_fill_done, d_fill_done}), 64'(de.sd));
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_we_i, fill_we_d,
                    fill_word, fill_data, i_fill_done, d_fill_done, d_wr_done, busy});
    endfunction

    // which: 0 = i_fill_done, 1 = d_fill_done, 2 = d_wr_done
    task automatic wait_sig(input int which, input int budget);
        int n;
        logic s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            s = (which == 0) ? i_fill_done : (which == 1) ? d_fill_done : d_wr_done;
        end while (!s && n < budget);
        if (!s) begin
            total++; bad++;
            $display("FAIL wait_%0d: got no pulse within %0d cycles want pulse", which, budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t0;

    initial begin
        rst = 1'b1;
        i_miss = 0; d_miss = 0; d_wr_req = 0;
        i_addr = 0; d_addr = 0; d_wr_addr = 0; d_wr_data = 0;
        idle_cycles(3);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        idle_cycles(1);

        // I-fill alone, unaligned address
        t0 = cyc;
        i_miss = 1; i_addr = 16'h1236;
        push_fill(1'b0, 16'h1230, t0 + 1);
        wait_sig(0, 40);
        i_miss = 0;
        chk("busy_after_ifill", 64'(busy), 64'd0);
        idle_cycles(2);

        // Simultaneous I and D misses: D first, I after one IDLE cycle
        t0 = cyc;
        i_miss = 1; i_addr = 16'h0040;
        d_miss = 1; d_addr = 16'h2008;
        push_fill(1'b1, 16'h2000, t0 + 1);
        push_fill(1'b0, 16'h0040, t0 + 15);
        wait_sig(1, 40);
        d_miss = 0;
        wait_sig(0, 40);
        i_miss = 0;
        idle_cycles(2);

        // Write-through beats a pending I miss
        t0 = cyc;
        d_wr_req = 1; d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF;
        i_miss = 1; i_addr = 16'h0A04;
        mem_q.push_back('{t0 + 1, 16'h0100, 16'hBEEF, 1'b1});
        push_fill(1'b0, 16'h0A00, t0 + 3);
        wait_sig(2, 10);
        d_wr_req = 0;
        wait_sig(0, 40);
        i_miss = 0;
        idle_cycles(2);

        // Top-of-memory block stays inside 0xFFF0..0xFFFE
        t0 = cyc;
        i_miss = 1; i_addr = 16'hFFFE;
        push_fill(1'b0, 16'hFFF0, t0 + 1);
        wait_sig(0, 40);
        i_miss = 0;
        idle_cycles(2);

        // Stray data valid in IDLE
        stray_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_idle_outputs", all_outs(), 64'd0);
            @(posedge clk);
            #1;
        end
        stray_v = 1'b0;
        idle_cycles(1);
        chk("stray_busy", 64'(busy), 64'd0);

        // Reset in cycle 6 of a D fill
        t0 = cyc;
        d_miss = 1; d_addr = 16'h3004;
        for (int k = 0; k < 6; k++) mem_q.push_back('{t0 + 1 + k, 16'h3000 + 16'(2 * k), 16'h0, 1'b0});
        fill_q.push_back('{t0 + 5, 2'b01, 3'd0, memf(16'h3000)});
        fill_q.push_back('{t0 + 6, 2'b01, 3'd1, memf(16'h3002)});
        idle_cycles(6);
        rst = 1'b1;
        d_miss = 0;
        idle_cycles(1);
        rst = 1'b0;
        stray_v = 1'b1;
        for (int k = 7; k <= 12; k++) begin
            @(negedge clk);
            chk("post_reset_outputs", all_outs(), 64'd0);
            @(posedge clk);
            #1;
        end
        stray_v = 1'b0;
        idle_cycles(4);

        chk("mem_q_drained", 64'(mem_q.size()), 64'd0);
        chk("fill_q_drained", 64'(fill_q.size()), 64'd0);
        chk("done_q_drained", 64'(done_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
